bus_arbiter_mux: RTL and testbench

BUS_ARBITER_MUX -- requirements
Module: bus_arbiter_mux

---
 rtl/bus_pkg.sv | 18 +
 rtl/rr_priority_picker.sv | 40 ++++
 rtl/bus_arbiter_mux.sv | 110 +++++++++++
 tb/tb_bus_arbiter_mux.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared constants for the bus arbiter/mux: default widths, idle bus value and
// arbitration mode encodings.
package bus_pkg;

    localparam int unsigned BUS_WIDTH      = 32;
    localparam logic [31:0] BUS_IDLE_VALUE = 32'h0000_1000;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    localparam int unsigned CNT_W = 16;

    // True when a request vector has more than one bit set.
    function automatic logic multi_hot(input logic [31:0] vec);
        return |(vec & (vec - 32'd1));
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational winner search: first set request at or above start_i,
// wrapping modulo N. A start of 0 gives plain lowest-index priority.
module rr_priority_picker #(
    parameter int unsigned N    = 25,
    parameter int unsigned SELW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [SELW-1:0] start_i,
    output logic [N-1:0]    gnt_o,
    output logic [SELW-1:0] idx_o,
    output logic            any_o
);

    int unsigned     pos;
    logic [SELW-1:0] sel;
    logic            found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        sel   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // start_i is always < N, so one subtraction is enough to wrap.
            pos = 32'(start_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            sel = SELW'(pos);
            if (!found && req_i[sel]) begin
                found      = 1'b1;
                gnt_o[sel] = 1'b1;
                idx_o      = sel;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered N-source bus arbiter and data mux with conflict detection, hold
// (stall) and synchronous clear.
module bus_arbiter_mux
    import bus_pkg::*;
#(
    parameter int unsigned      WIDTH      = BUS_WIDTH,
    parameter int unsigned      N_SRC      = 25,
    parameter int unsigned      SELW       = $clog2(N_SRC),
    parameter int unsigned      MODE       = ARB_FIXED,
    parameter logic [WIDTH-1:0] IDLE_VALUE = WIDTH'(BUS_IDLE_VALUE)
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic [N_SRC-1:0]       src_req,
    input  logic                   hold,
    output logic [WIDTH-1:0]       bus_out,
    output logic                   bus_valid,
    output logic [N_SRC-1:0]       grant,
    output logic [SELW-1:0]        grant_idx,
    output logic                   conflict,
    output logic [CNT_W-1:0]       conflict_count
);

    logic [WIDTH-1:0] words [N_SRC];

    for (genvar i = 0; i < N_SRC; i++) begin : g_words
        assign words[i] = src_data[i*WIDTH +: WIDTH];
    end

    logic [WIDTH-1:0] bus_q, bus_d;
    logic             valid_q, valid_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [SELW-1:0]  idx_q, idx_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
    logic             conflict_q, conflict_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [N_SRC-1:0] pick_gnt;
    logic [SELW-1:0]  pick_idx;
    logic [SELW-1:0]  pick_start;
    logic             pick_any;
    logic             multi;

    assign pick_start = (MODE == ARB_RR) ? rr_ptr_q : '0;

    rr_priority_picker #(
        .N    (N_SRC),
        .SELW (SELW)
    ) u_picker (
        .req_i   (src_req),
        .start_i (pick_start),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign multi = |(src_req & (src_req - N_SRC'(1)));

    always_comb begin
        bus_d      = IDLE_VALUE;
        valid_d    = 1'b0;
        grant_d    = '0;
        idx_d      = '0;
        rr_ptr_d   = rr_ptr_q;
        conflict_d = multi;
        count_d    = count_q;
        if (pick_any) begin
            bus_d    = words[pick_idx];
            valid_d  = 1'b1;
            grant_d  = pick_gnt;
            idx_d    = pick_idx;
            // N_SRC need not be a power of two, so wrap explicitly.
            rr_ptr_d = (pick_idx == SELW'(N_SRC - 1)) ? '0 : pick_idx + SELW'(1);
        end
        if (multi && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            bus_q      <= IDLE_VALUE;
            valid_q    <= 1'b0;
            grant_q    <= '0;
            idx_q      <= '0;
            rr_ptr_q   <= '0;
            conflict_q <= 1'b0;
            count_q    <= '0;
        end else if (hold) begin
            conflict_q <= 1'b0;
        end else begin
            bus_q      <= bus_d;
            valid_q    <= valid_d;
            grant_q    <= grant_d;
            idx_q      <= idx_d;
            rr_ptr_q   <= rr_ptr_d;
            conflict_q <= conflict_d;
            count_q    <= count_d;
        end
    end

    assign bus_out        = bus_q;
    assign bus_valid      = valid_q;
    assign grant          = grant_q;
    assign grant_idx      = idx_q;
    assign conflict       = conflict_q;
    assign conflict_count = count_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Scoreboard bench: a fixed-priority and a round-robin instance share stimulus;
// a behavioural model pushes expected outputs, which are popped after each edge.
module tb_bus_arbiter_mux;

    localparam int unsigned W = 32;
    localparam int unsigned N = 25;
    localparam int unsigned S = 5;

    typedef struct {
        logic [W-1:0] bus;
        logic         valid;
        logic [N-1:0] gnt;
        logic [S-1:0] idx;
        logic         conf;
        logic [15:0]  cnt;
    } exp_t;

    logic           clock = 1'b0;
    logic           clear = 1'b1;
    logic           hold  = 1'b0;
    logic [N*W-1:0] src_data = '0;
    logic [N-1:0]   src_req  = '0;

    logic [W-1:0] f_bus,   r_bus;
    logic         f_valid, r_valid;
    logic [N-1:0] f_gnt,   r_gnt;
    logic [S-1:0] f_idx,   r_idx;
    logic         f_conf,  r_conf;
    logic [15:0]  f_cnt,   r_cnt;

    bus_arbiter_mux #(.WIDTH(W), .N_SRC(N), .SELW(S), .MODE(0), .IDLE_VALUE(32'h0000_1000)) u_fixed (
        .clock (clock), .clear (clear), .src_data (src_data), .src_req (src_req), .hold (hold),
        .bus_out (f_bus), .bus_valid (f_valid), .grant (f_gnt), .grant_idx (f_idx),
        .conflict (f_conf), .conflict_count (f_cnt)
    );

    bus_arbiter_mux #(.WIDTH(W), .N_SRC(N), .SELW(S), .MODE(1), .IDLE_VALUE(32'h0000_1000)) u_rr (
        .clock (clock), .clear (clear), .src_data (src_data), .src_req (src_req), .hold (hold),
        .bus_out (r_bus), .bus_valid (r_valid), .grant (r_gnt), .grant_idx (r_idx),
        .conflict (r_conf), .conflict_count (r_cnt)
    );

    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t st [2];
    int   rr_m [2];
    exp_t q0 [$];
    exp_t q1 [$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t reset_val();
        exp_t e;
        e.bus = 32'h0000_1000; e.valid = 1'b0; e.gnt = '0; e.idx = '0; e.conf = 1'b0; e.cnt = '0;
        return e;
    endfunction

    task automatic set_word(input int i, input logic [W-1:0] v);
        src_data[i*W +: W] = v;
    endtask

    task automatic model_push();
        for (int m = 0; m < 2; m++) begin
            exp_t e;
            int   w;
            int   start;
            int   pc;
            e = st[m];
            if (clear) begin
                e = reset_val();
                rr_m[m] = 0;
            end else if (hold) begin
                e.conf = 1'b0;
            end else begin
                w = -1;
                pc = 0;
                start = (m == 0) ? 0 : rr_m[m];
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && src_req[(start + k) % N]) w = (start + k) % N;
                    if (src_req[k]) pc++;
                end
                e.conf = (pc > 1);
                if (e.conf && e.cnt != 16'hFFFF) e.cnt = e.cnt + 16'd1;
                if (w >= 0) begin
                    e.bus   = src_data[w*W +: W];
                    e.valid = 1'b1;
                    e.gnt   = '0;
                    e.gnt[w] = 1'b1;
                    e.idx   = S'(w);
                    rr_m[m] = (w + 1) % N;
                end else begin
                    e.bus = 32'h0000_1000; e.valid = 1'b0; e.gnt = '0; e.idx = '0;
                end
            end
            st[m] = e;
            if (m == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        check_eq("sb_depth_fixed", 64'(q0.size()), 64'd1);
        check_eq("sb_depth_rr", 64'(q1.size()), 64'd1);
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check_eq("fixed_bus", 64'(f_bus), 64'(e.bus));
            check_eq("fixed_valid", 64'(f_valid), 64'(e.valid));
            check_eq("fixed_grant", 64'(f_gnt), 64'(e.gnt));
            check_eq("fixed_idx", 64'(f_idx), 64'(e.idx));
            check_eq("fixed_conflict", 64'(f_conf), 64'(e.conf));
            check_eq("fixed_count", 64'(f_cnt), 64'(e.cnt));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check_eq("rr_bus", 64'(r_bus), 64'(e.bus));
            check_eq("rr_valid", 64'(r_valid), 64'(e.valid));
            check_eq("rr_grant", 64'(r_gnt), 64'(e.gnt));
            check_eq("rr_idx", 64'(r_idx), 64'(e.idx));
            check_eq("rr_conflict", 64'(r_conf), 64'(e.conf));
            check_eq("rr_count", 64'(r_cnt), 64'(e.cnt));
        end
    endtask

    task automatic step(input logic [N-1:0] req, input logic hld, input logic clr);
        src_req = req;
        hold    = hld;
        clear   = clr;
        model_push();
        @(posedge clock);
        #1;
        compare_pop();
    endtask

    int unsigned rr_seq [4] = '{0, 5, 24, 0};

    initial begin
        st[0] = reset_val();
        st[1] = reset_val();
        rr_m[0] = 0;
        rr_m[1] = 0;
        for (int i = 0; i < N; i++) set_word(i, 32'hC0DE_0000 | W'(i));
        set_word(21, 32'h0000_0040);

        // Reset, then idle bus.
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0);
        check_eq("idle_bus", 64'(f_bus), 64'h0000_1000);
        check_eq("idle_count", 64'(f_cnt), 64'd0);

        // Single source 21 (PC).
        step(N'(1) << 21, 1'b0, 1'b0);
        check_eq("pc_bus", 64'(f_bus), 64'h0000_0040);
        check_eq("pc_idx", 64'(f_idx), 64'd21);

        // Conflict between 3 and 7, then a quiet cycle.
        step((N'(1) << 3) | (N'(1) << 7), 1'b0, 1'b0);
        check_eq("conf_idx", 64'(f_idx), 64'd3);
        check_eq("conf_pulse", 64'(f_conf), 64'd1);
        check_eq("conf_count", 64'(f_cnt), 64'd1);
        step('0, 1'b0, 1'b0);

        // Round-robin wrap from a cleared pointer.
        step('0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(N'(1) | (N'(1) << 5) | (N'(1) << 24), 1'b0, 1'b0);
            check_eq("rr_seq", 64'(r_idx), 64'(rr_seq[k]));
        end

        // Hold freezes the grant of source 2 even while its data and requests change.
        step(N'(1) << 2, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            set_word(2, 32'hBAD0_0000 | W'(k));
            step(N'(1) << 9, 1'b1, 1'b0);
            check_eq("hold_idx", 64'(f_idx), 64'd2);
        end
        step(N'(1) << 9, 1'b0, 1'b0);
        check_eq("unhold_idx", 64'(f_idx), 64'd9);

        // Random traffic with occasional hold/clear.
        for (int k = 0; k < 300; k++) begin
            logic [N-1:0] r;
            r = N'($urandom);
            case ($urandom_range(0, 3))
                0: r = '0;
                1: r = N'(1) << $urandom_range(0, N - 1);
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) set_word($urandom_range(0, N - 1), $urandom);
            step(r, $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0);
        end

        // Saturate the conflict counter, then clear and hold together.
        step('0, 1'b0, 1'b1);
        for (int k = 0; k < 65536; k++) step((N'(1) << 3) | (N'(1) << 7), 1'b0, 1'b0);
        check_eq("cnt_sat", 64'(f_cnt), 64'hFFFF);
        step((N'(1) << 3) | (N'(1) << 7), 1'b1, 1'b1);
        check_eq("clr_hold_bus", 64'(r_bus), 64'h0000_1000);
        check_eq("clr_hold_cnt", 64'(r_cnt), 64'd0);
        step(N'(1) | (N'(1) << 4), 1'b0, 1'b0);
        check_eq("post_clr_rr", 64'(r_idx), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
